// File: rtl/uart_rx_seq_checker.sv
// -----------------------------------------------------------------------------
// uart_rx_seq_checker
//
// Checking end of the incrementing-byte loopback pattern. Consumes the user
// receive stream of the UART driver, locks onto the incrementing sequence,
// tracks the next expected byte and counts received bytes and mismatches.
//
// Optional feature macro: UART_CHK_TIMEOUT_EN
//   defined   : idle counter while LOCKED; after P_TIMEOUT_CYCLES idle cycles
//               o_timeout is set (sticky) and lock is dropped.
//   undefined : no idle counter, o_timeout tied to 0.
//
// Handshake: i_rx_valid is a single-cycle strobe qualifying i_rx_data. There
// is no ready/backpressure; every cycle with i_rx_valid=1 is one byte and is
// always consumed, including back-to-back strobes.
//
// Ports:
//   clock        user clock
//   reset        asynchronous active-low reset
//   i_rx_data    received byte (qualified by i_rx_valid)
//   i_rx_valid   byte strobe
//   i_clear      synchronous clear of counters and FSM (highest priority)
//   o_locked     high while FSM is LOCKED
//   o_err_pulse  one-cycle pulse per mismatch while LOCKED
//   o_expect     next expected byte
//   o_byte_cnt   saturating count of valid bytes
//   o_err_cnt    saturating count of mismatches while LOCKED
//   o_timeout    sticky idle-timeout flag
//   o_dbg_state  current FSM state (0=HUNT, 1=SYNC, 2=LOCKED)
// -----------------------------------------------------------------------------
module uart_rx_seq_checker #(
  parameter int P_DATA_WIDTH     = 8,
  parameter int P_LOCK_COUNT     = 4,
  parameter int P_LOSS_COUNT     = 3,
  parameter int P_CNT_WIDTH      = 16,
  parameter int P_TIMEOUT_CYCLES = 100000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [P_DATA_WIDTH-1:0] i_rx_data,
  input  logic                    i_rx_valid,
  input  logic                    i_clear,
  output logic                    o_locked,
  output logic                    o_err_pulse,
  output logic [P_DATA_WIDTH-1:0] o_expect,
  output logic [P_CNT_WIDTH-1:0]  o_byte_cnt,
  output logic [P_CNT_WIDTH-1:0]  o_err_cnt,
  output logic                    o_timeout,
  output logic [1:0]              o_dbg_state
);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam int GW = $clog2(P_LOCK_COUNT + 1);
  localparam int BW = $clog2(P_LOSS_COUNT + 1);
  localparam logic [GW-1:0] LOCK_N = GW'(P_LOCK_COUNT);
  localparam logic [BW-1:0] LOSS_N = BW'(P_LOSS_COUNT);

  state_t                  r_state;
  logic                    r_locked;
  logic                    r_err_pulse;
  logic [P_DATA_WIDTH-1:0] r_expect;
  logic [P_CNT_WIDTH-1:0]  r_byte_cnt;
  logic [P_CNT_WIDTH-1:0]  r_err_cnt;
  logic [GW-1:0]           r_good;
  logic [BW-1:0]           r_bad;
  logic                    w_match;

`ifdef UART_CHK_TIMEOUT_EN
  localparam int IW = $clog2(P_TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(P_TIMEOUT_CYCLES - 1);
  logic [IW-1:0] r_idle;
  logic          r_timeout;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (P_TIMEOUT_CYCLES > 0);
`endif

  assign w_match = (i_rx_data == r_expect);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_HUNT;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_expect    <= '0;
      r_byte_cnt  <= '0;
      r_err_cnt   <= '0;
      r_good      <= '0;
      r_bad       <= '0;
`ifdef UART_CHK_TIMEOUT_EN
      r_idle      <= '0;
      r_timeout   <= 1'b0;
`endif
    end else if (i_clear) begin
      // Clear wins over a same-cycle byte; that byte is dropped uncounted.
      r_state     <= ST_HUNT;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_expect    <= '0;
      r_byte_cnt  <= '0;
      r_err_cnt   <= '0;
      r_good      <= '0;
      r_bad       <= '0;
`ifdef UART_CHK_TIMEOUT_EN
      r_idle      <= '0;
      r_timeout   <= 1'b0;
`endif
    end else begin
      r_err_pulse <= 1'b0;
      if (i_rx_valid && (r_byte_cnt != '1)) begin
        r_byte_cnt <= r_byte_cnt + 1'b1;
      end
      case (r_state)
        ST_HUNT: begin
          if (i_rx_valid) begin
            r_expect <= i_rx_data + 1'b1;
            r_good   <= GW'(1);
            r_state  <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (i_rx_valid) begin
            if (w_match) begin
              r_expect <= r_expect + 1'b1;
              r_good   <= r_good + 1'b1;
              if ((r_good + 1'b1) == LOCK_N) begin
                r_state  <= ST_LOCKED;
                r_locked <= 1'b1;
                r_bad    <= '0;
              end
            end else begin
              // Resync on the received byte; mismatches before lock are not errors.
              r_expect <= i_rx_data + 1'b1;
              r_good   <= GW'(1);
            end
          end
        end
        ST_LOCKED: begin
          if (i_rx_valid) begin
`ifdef UART_CHK_TIMEOUT_EN
            r_idle <= '0;
`endif
            if (w_match) begin
              r_expect <= r_expect + 1'b1;
              r_bad    <= '0;
            end else begin
              r_err_pulse <= 1'b1;
              if (r_err_cnt != '1) begin
                r_err_cnt <= r_err_cnt + 1'b1;
              end
              // Realign to the received byte so a single slip costs one error.
              r_expect <= i_rx_data + 1'b1;
              r_bad    <= r_bad + 1'b1;
              if ((r_bad + 1'b1) == LOSS_N) begin
                r_state  <= ST_HUNT;
                r_locked <= 1'b0;
                r_bad    <= '0;
                r_good   <= '0;
              end
            end
          end
`ifdef UART_CHK_TIMEOUT_EN
          else if (r_idle == IDLE_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= ST_HUNT;
            r_locked  <= 1'b0;
            r_idle    <= '0;
            r_good    <= '0;
            r_bad     <= '0;
          end else begin
            r_idle <= r_idle + 1'b1;
          end
`endif
        end
        default: begin
          r_state  <= ST_HUNT;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign o_locked    = r_locked;
  assign o_err_pulse = r_err_pulse;
  assign o_expect    = r_expect;
  assign o_byte_cnt  = r_byte_cnt;
  assign o_err_cnt   = r_err_cnt;
  assign o_dbg_state = r_state;
`ifdef UART_CHK_TIMEOUT_EN
  assign o_timeout   = r_timeout;
`else
  assign o_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_seq_checker.sv
module tb_uart_rx_seq_checker;

  localparam int TO_CYCLES = 50;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_rx_valid = 1'b0;
  logic        i_clear = 1'b0;
  logic        o_locked;
  logic        o_err_pulse;
  logic [7:0]  o_expect;
  logic [15:0] o_byte_cnt;
  logic [15:0] o_err_cnt;
  logic        o_timeout;
  logic [1:0]  o_dbg_state;

  always #5 clock = ~clock;

  uart_rx_seq_checker #(
    .P_DATA_WIDTH(8), .P_LOCK_COUNT(4), .P_LOSS_COUNT(3),
    .P_CNT_WIDTH(16), .P_TIMEOUT_CYCLES(TO_CYCLES)
  ) dut (
    .clock(clock), .reset(reset), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .i_clear(i_clear), .o_locked(o_locked), .o_err_pulse(o_err_pulse),
    .o_expect(o_expect), .o_byte_cnt(o_byte_cnt), .o_err_cnt(o_err_cnt),
    .o_timeout(o_timeout), .o_dbg_state(o_dbg_state)
  );

  // ---------------- reference model ----------------
  // mode: 0 = hunting, 1 = syncing, 2 = locked
  int          m_mode;
  int          m_good, m_bad, m_idle;
  logic [7:0]  m_expect;
  logic [15:0] m_byte_cnt, m_err_cnt;
  logic        m_err_pulse, m_timeout;

  int n_pass  = 0;
  int n_total = 0;

  task automatic model_reset();
    m_mode = 0; m_good = 0; m_bad = 0; m_idle = 0;
    m_expect = 8'h00; m_byte_cnt = 16'h0; m_err_cnt = 16'h0;
    m_err_pulse = 1'b0; m_timeout = 1'b0;
  endtask

  task automatic model_step(input logic valid, input logic [7:0] data, input logic clr);
    m_err_pulse = 1'b0;
    if (clr) begin
      model_reset();
      return;
    end
    if (!valid) begin
`ifdef UART_CHK_TIMEOUT_EN
      if (m_mode == 2) begin
        m_idle++;
        if (m_idle == TO_CYCLES) begin
          m_timeout = 1'b1; m_mode = 0; m_idle = 0;
        end
      end
`endif
      return;
    end
    m_idle = 0;
    if (m_byte_cnt != 16'hFFFF) m_byte_cnt++;
    if (m_mode == 0) begin
      m_expect = data + 8'd1; m_good = 1; m_mode = 1;
    end else if (m_mode == 1) begin
      if (data == m_expect) begin
        m_expect = m_expect + 8'd1; m_good++;
        if (m_good == 4) begin m_mode = 2; m_bad = 0; end
      end else begin
        m_expect = data + 8'd1; m_good = 1;
      end
    end else begin
      if (data == m_expect) begin
        m_expect = m_expect + 8'd1; m_bad = 0;
      end else begin
        m_err_pulse = 1'b1;
        if (m_err_cnt != 16'hFFFF) m_err_cnt++;
        m_expect = data + 8'd1; m_bad++;
        if (m_bad == 3) begin m_mode = 0; m_bad = 0; end
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".locked"},    32'(o_locked),    32'(m_mode == 2));
    chk({tag, ".err_pulse"}, 32'(o_err_pulse), 32'(m_err_pulse));
    chk({tag, ".expect"},    32'(o_expect),    32'(m_expect));
    chk({tag, ".byte_cnt"},  32'(o_byte_cnt),  32'(m_byte_cnt));
    chk({tag, ".err_cnt"},   32'(o_err_cnt),   32'(m_err_cnt));
    chk({tag, ".timeout"},   32'(o_timeout),   32'(m_timeout));
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after the rising edge; outputs sampled there too.
  task automatic step(input logic valid, input logic [7:0] data, input logic clr, input string tag);
    i_rx_valid = valid; i_rx_data = data; i_clear = clr;
    @(posedge clock);
    model_step(valid, data, clr);
    #1;
    i_rx_valid = 1'b0; i_clear = 1'b0;
    check_all(tag);
  endtask

  task automatic send_run(input logic [7:0] start, input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b1, start + 8'(i), 1'b0, tag);
  endtask

  int err_pulses;

  initial begin
    model_reset();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_all("reset");
    reset = 1'b1;

    // 1: lock on 0x10..0x13
    send_run(8'h10, 3, "t1");
    chk("t1.pre_lock", 32'(o_locked), 32'd0);
    step(1'b1, 8'h13, 1'b0, "t1");
    chk("t1.locked", 32'(o_locked), 32'd1);
    chk("t1.expect", 32'(o_expect), 32'h14);
    chk("t1.bytes",  32'(o_byte_cnt), 32'd4);
    chk("t1.errs",   32'(o_err_cnt), 32'd0);

    // 2: wrap while locked
    step(1'b0, 8'h00, 1'b1, "t2clr");
    send_run(8'hFA, 4, "t2lock");
    err_pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'hFE + 8'(i), 1'b0, "t2");
      if (o_err_pulse) err_pulses++;
    end
    chk("t2.no_err", 32'(err_pulses), 32'd0);
    chk("t2.expect", 32'(o_expect), 32'h02);
    chk("t2.locked", 32'(o_locked), 32'd1);

    // 3: single slip realigns
    step(1'b0, 8'h00, 1'b1, "t3clr");
    send_run(8'h1C, 4, "t3lock");
    err_pulses = 0;
    step(1'b1, 8'h20, 1'b0, "t3"); if (o_err_pulse) err_pulses++;
    step(1'b1, 8'h55, 1'b0, "t3"); if (o_err_pulse) err_pulses++;
    step(1'b1, 8'h56, 1'b0, "t3"); if (o_err_pulse) err_pulses++;
    chk("t3.pulses", 32'(err_pulses), 32'd1);
    chk("t3.errs",   32'(o_err_cnt), 32'd1);
    chk("t3.expect", 32'(o_expect), 32'h57);
    chk("t3.locked", 32'(o_locked), 32'd1);

    // 4: loss of lock then relock
    step(1'b0, 8'h00, 1'b1, "t4clr");
    send_run(8'h30, 4, "t4lock");
    err_pulses = 0;
    step(1'b1, 8'h00, 1'b0, "t4"); if (o_err_pulse) err_pulses++;
    step(1'b1, 8'h80, 1'b0, "t4"); if (o_err_pulse) err_pulses++;
    step(1'b1, 8'h40, 1'b0, "t4"); if (o_err_pulse) err_pulses++;
    chk("t4.pulses", 32'(err_pulses), 32'd3);
    chk("t4.errs",   32'(o_err_cnt), 32'd3);
    chk("t4.unlock", 32'(o_locked), 32'd0);
    send_run(8'h41, 4, "t4relock");
    chk("t4.relock", 32'(o_locked), 32'd1);

    // 5: clear with simultaneous byte, then async reset mid-stream
    step(1'b0, 8'h00, 1'b1, "t5clr");
    send_run(8'h00, 9, "t5fill");
    chk("t5.bytes9", 32'(o_byte_cnt), 32'd9);
    step(1'b1, 8'h09, 1'b1, "t5clrv");
    chk("t5.bytes0", 32'(o_byte_cnt), 32'd0);
    chk("t5.unlock", 32'(o_locked), 32'd0);
    chk("t5.expect0", 32'(o_expect), 32'd0);
    send_run(8'hA0, 2, "t5pre");
    i_rx_valid = 1'b1; i_rx_data = 8'hA2;
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("t5.async");
    @(posedge clock);
    #1;
    i_rx_valid = 1'b0;
    reset = 1'b1;
    step(1'b1, 8'h77, 1'b0, "t5hunt");
    chk("t5.hunt_expect", 32'(o_expect), 32'h78);

    // 6: idle while locked
    step(1'b0, 8'h00, 1'b1, "t6clr");
    send_run(8'h60, 4, "t6lock");
    for (int i = 0; i < TO_CYCLES; i++) step(1'b0, 8'h00, 1'b0, "t6idle");
`ifdef UART_CHK_TIMEOUT_EN
    chk("t6.timeout", 32'(o_timeout), 32'd1);
    chk("t6.locked",  32'(o_locked), 32'd0);
`else
    chk("t6.timeout", 32'(o_timeout), 32'd0);
    chk("t6.locked",  32'(o_locked), 32'd1);
`endif

    // 7: randomized stream against the model
    step(1'b0, 8'h00, 1'b1, "t7clr");
    for (int i = 0; i < 600; i++) begin
      logic       v, c;
      logic [7:0] d;
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 99) == 0);
      d = ($urandom_range(0, 5) == 0) ? 8'($urandom) : m_expect;
      step(v, d, c, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
